// File: rtl/scan_chain_ctrl.sv
// rtl/scan_chain_ctrl.sv - scan chain with capture/shift/update transfer controller
// Optional parity cell: define SCAN_CHAIN_PARITY_EN.
module scan_chain_ctrl #(
  parameter int IN_W = 20,
  parameter int OUT_W = 20,
  parameter logic [IN_W-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             scan_in,
  input  logic             scan_vld,
  output logic             scan_out,
  output logic             busy,
  output logic             done,
  output logic             par_err,
  output logic [IN_W-1:0]  core_drive,
  input  logic [OUT_W-1:0] core_sample
);

`ifdef SCAN_CHAIN_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L = OUT_W + IN_W + P;
  localparam int CW = $clog2(L + 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, SHIFT, UPDATE} state_t;

  state_t          state;
  logic [L-1:0]    sr;
  logic [CW-1:0]   shift_cnt;
  logic            upd_ok;

`ifdef SCAN_CHAIN_PARITY_EN
  // Drive field plus parity cell must have even parity for the update to land.
  assign upd_ok = ~(^sr[IN_W+P-1:0]);
`else
  assign upd_ok = 1'b1;
`endif

  assign scan_out = sr[L-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      shift_cnt  <= '0;
      core_drive <= RESET_VAL;
      busy       <= 1'b0;
      done       <= 1'b0;
      par_err    <= 1'b0;
    end else begin
      done    <= 1'b0;
      par_err <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= CAPTURE;
            busy  <= 1'b1;
          end
        end
        CAPTURE: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            sr[L-1:IN_W+P] <= core_sample;
            shift_cnt      <= '0;
            state          <= SHIFT;
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (scan_vld) begin
            sr        <= {sr[L-2:0], scan_in};
            shift_cnt <= shift_cnt + CW'(1);
            if (shift_cnt == CW'(L - 1)) state <= UPDATE;
          end
        end
        UPDATE: begin
          if (upd_ok) core_drive <= sr[IN_W+P-1:P];
          par_err <= ~upd_ok;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// tb/tb_scan_chain_ctrl.sv - randomized self-checking bench for scan_chain_ctrl
module tb_scan_chain_ctrl;
  localparam int IN_W = 4;
  localparam int OUT_W = 3;
  localparam logic [IN_W-1:0] RESET_VAL = '0;
`ifdef SCAN_CHAIN_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int L = OUT_W + IN_W + P;

  logic clk = 1'b0;
  logic rst, start, abort, scan_in, scan_vld;
  logic scan_out, busy, done, par_err;
  logic [IN_W-1:0] core_drive;
  logic [OUT_W-1:0] core_sample;

  int n_cmp = 0;
  int n_err = 0;

  // Chain model: element 0 is the next bit to leave on scan_out.
  logic mq[$];
  logic [IN_W-1:0] model_drive;

  always #5 clk = ~clk;

  scan_chain_ctrl #(.IN_W(IN_W), .OUT_W(OUT_W), .RESET_VAL(RESET_VAL)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .scan_in(scan_in), .scan_vld(scan_vld), .scan_out(scan_out),
    .busy(busy), .done(done), .par_err(par_err),
    .core_drive(core_drive), .core_sample(core_sample)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < L; i++) mq.push_back(1'b0);
    model_drive = RESET_VAL;
  endtask

  // pace: 0 back-to-back, 1 every other cycle, 2 random gaps.
  // bits[k] is the k-th bit sent by the host.
  task automatic run_xfer(input logic [OUT_W-1:0] samp, input logic [31:0] bits,
                          input int pace, input int abort_at, input bit stray,
                          input int rst_at);
    int cyc;
    int k;
    bit gap;
    bit perr;
    logic [IN_W-1:0] exp_drive;
    logic par;
    start = 1'b1;
    core_sample = samp;
    cyc = 0;
    @(posedge clk); #1; start = 1'b0; cyc++;
    chk("busy_capture", busy, 1);
    @(posedge clk); #1; cyc++;
    for (int i = 0; i < OUT_W; i++) mq[i] = samp[OUT_W-1-i];
    k = 0;
    gap = 1'b0;
    while (k < L) begin
      chk("scan_out", scan_out, mq[0]);
      chk("busy_shift", busy, 1);
      chk("done_shift", done, 0);
      if (k == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_drive", core_drive, RESET_VAL);
        chk("rst_scan_out", scan_out, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1; rst = 1'b0;
        model_reset();
        return;
      end
      if (k == abort_at) begin
        abort = 1'b1; scan_vld = 1'b1; scan_in = bits[k];
        @(posedge clk); #1; abort = 1'b0; scan_vld = 1'b0;
        chk("abort_busy", busy, 0);
        @(posedge clk); #1;
        chk("abort_done", done, 0);
        chk("abort_drive", core_drive, model_drive);
        return;
      end
      gap = (pace == 1) ? ~gap : (pace == 2) ? ($urandom_range(2) == 0) : 1'b0;
      if (gap) begin
        scan_vld = 1'b0; scan_in = 1'($urandom); start = stray;
        @(posedge clk); #1; start = 1'b0; cyc++;
        continue;
      end
      scan_vld = 1'b1; scan_in = bits[k];
      @(posedge clk); #1; cyc++;
      void'(mq.pop_front());
      mq.push_back(bits[k]);
      k++;
    end
    scan_vld = 1'b0;
    chk("busy_update", busy, 1);
    chk("done_update", done, 0);
    for (int i = 0; i < IN_W; i++) exp_drive[IN_W-1-i] = mq[OUT_W+i];
    par = ^exp_drive;
    if (P == 1) par = par ^ mq[OUT_W+IN_W];
    perr = (P == 1) && par;
    if (perr) exp_drive = model_drive;
    @(posedge clk); #1; cyc++;
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 0);
    chk("par_err", par_err, perr);
    chk("drive", core_drive, exp_drive);
    if (pace == 0) chk("latency", cyc, L + 3);
    model_drive = exp_drive;
    @(posedge clk); #1;
    chk("done_clear", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    logic [31:0] rb;
    rst = 1'b1; start = 1'b0; abort = 1'b0; scan_in = 1'b0; scan_vld = 1'b0;
    core_sample = '0;
    model_reset();
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_par_err", par_err, 0);
    chk("reset_scan_out", scan_out, 0);
    chk("reset_drive", core_drive, RESET_VAL);
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;

    // Send order 0,0,0,1,0,1,1 (+ parity 1): bits 3,5,6 (and 7) set.
    run_xfer(3'b101, (P == 1) ? 32'hE8 : 32'h68, 0, -1, 1'b0, -1);
    chk("basic_drive", core_drive, 4'b1011);
    run_xfer(3'b101, (P == 1) ? 32'hE8 : 32'h68, 1, -1, 1'b0, -1);
    chk("paced_drive", core_drive, 4'b1011);
    run_xfer(3'b010, 32'h55, 0, 4, 1'b0, -1);
    run_xfer(3'b011, 32'h2A, 0, -1, 1'b0, -1);
    run_xfer(3'b110, 32'h11, 1, -1, 1'b1, -1);
`ifdef SCAN_CHAIN_PARITY_EN
    run_xfer(3'b101, 32'hE8, 0, -1, 1'b0, -1);
    chk("parity_ok_drive", core_drive, 4'b1011);
    run_xfer(3'b101, 32'h68, 0, -1, 1'b0, -1);
    chk("parity_bad_drive", core_drive, 4'b1011);
`endif
    run_xfer(3'b111, 32'h7F, 0, -1, 1'b0, 3);
    run_xfer(3'b001, 32'h0F, 0, -1, 1'b0, -1);

    for (int t = 0; t < 40; t++) begin
      rb = $urandom;
      run_xfer(OUT_W'($urandom), rb, int'($urandom_range(2)),
               ($urandom_range(5) == 0) ? int'($urandom_range(L - 1)) : -1,
               1'($urandom), ($urandom_range(11) == 0) ? int'($urandom_range(L - 1)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scan_chain_ctrl.md
# scan_chain_ctrl

Parametrised, single-clock scan chain with a built-in transfer controller. It is the next generation of the hand-instanced chain that drives SRAM data, address and select bits into the core and reads back pixel coordinates. Drive width and sample width are set by parameters. A handshaked capture → shift → update sequence with a bit counter replaces externally sequenced phi/phib/load pins. The block sits between the off-chip scan pins and the core's debug/config ports.

## Interface
- IN_W, 20: number of drive cells (bits scanned into the core, e.g. din/addr/sram_sel).
- OUT_W, 20: number of sample cells (bits captured from the core, e.g. x/y).
- RESET_VAL, 0: reset value of core_drive, IN_W bits.
- clk  in  1  block clock.
- rst  in  1  reset, active-high; one clock; reset is asynchronous and active-high.
- start  in  1  begin one transfer; accepted only in IDLE.
- abort  in  1  cancel transfer in CAPTURE/SHIFT.
- scan_in  in  1  serial data from host.
- scan_vld  in  1  scan_in valid this cycle; shifts one bit in SHIFT.
- scan_out  out  1  serial data to host, always = sr[L-1].
- busy  out  1  high in CAPTURE, SHIFT, UPDATE.
- done  out  1  one-cycle pulse at end of a completed transfer.
- par_err  out  1  one-cycle pulse with done on parity failure (tied 0 without macro).
- core_drive  out  IN_W  bits held to the core.
- core_sample  in  OUT_W  bits sampled from the core.

## Operation
- Chain register sr of length L = OUT_W + IN_W + P, where P = 1 with SCAN_CHAIN_PARITY_EN and P = 0 otherwise.
  - sr[P-1:0] holds the parity cell.
  - sr[IN_W+P-1:P] holds the drive field.
  - sr[L-1:IN_W+P] holds the sample field.
- Shift: sr[0] ← scan_in, sr[i] ← sr[i-1]. The bit at sr[L-1] is lost.
- Host bit order:
  - Send OUT_W filler bits first, then core_drive MSB→LSB, then the parity bit if enabled.
  - scan_out yields core_sample MSB→LSB, then the previous drive field MSB→LSB.
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE.
  - IDLE→CAPTURE on start.
  - CAPTURE, always one cycle: sr sample field ← core_sample; drive and parity fields unchanged; shift_cnt ← 0. Then →SHIFT.
  - SHIFT: each scan_vld cycle shifts sr and increments shift_cnt, which is $clog2(L+1) bits wide. When the L-th bit is accepted, →UPDATE.
  - UPDATE, one cycle: core_drive ← sr drive field (unless a parity failure), done ← 1. Then →IDLE.
  - abort in CAPTURE or SHIFT: →IDLE, no done, core_drive unchanged, sr keeps its partial contents.
- Ignored inputs:
  - start is ignored while busy.
  - scan_vld is ignored outside SHIFT.
  - abort is ignored in IDLE and UPDATE.
- abort and scan_vld in the same cycle: abort wins, no shift.
- Reset (any time, including mid-transfer):
  - state IDLE, sr = 0, shift_cnt = 0.
  - core_drive = RESET_VAL.
  - busy, done, par_err = 0; scan_out = 0.

## Timing
- start sampled at edge t: CAPTURE during t..t+1, SHIFT from t+1.
- scan_out shows core_sample[OUT_W-1] in the first SHIFT cycle.
- One bit per scan_vld cycle, with no bubbles required. Minimum transfer is L + 3 cycles from start to done.
- At the UPDATE closing edge:
  - core_drive takes its new value;
  - done = 1 for exactly one cycle;
  - busy = 0 in that same cycle.
- start asserted in the done cycle is accepted.
- core_drive changes only at the UPDATE exit edge or on reset; it is glitch-free registered.

## Configuration
- SCAN_CHAIN_PARITY_EN defined:
  - L includes one parity cell.
  - In UPDATE, if XOR(drive field, parity cell) ≠ 0, core_drive is held and par_err pulses with done.
- SCAN_CHAIN_PARITY_EN undefined: L = OUT_W + IN_W, par_err constant 0, update is unconditional.

## Test plan
- Reset: assert rst mid-SHIFT → busy = 0, core_drive = RESET_VAL, scan_out = 0 on the same cycle; next start works normally.
- Basic transfer (IN_W = 4, OUT_W = 3, no macro):
  - Stimulus: core_sample = 3'b101; shift 0,0,0,1,0,1,1.
  - scan_out = 1,0,1,0,0,0,0; core_drive = 4'b1011; done pulses once, 10 cycles after start.
- Paced shifting: same transfer with scan_vld toggling every other cycle → identical result; shift_cnt does not advance on idle cycles.
- Abort: abort after 4 bits, with scan_vld also high → no done; core_drive keeps its prior value; a following full transfer succeeds.
- start while busy: pulse start in SHIFT → ignored; exactly one done.
- Parity (macro on, L = 8):
  - Bits 0,0,0,1,0,1,1 plus parity 1 → core_drive = 1011, par_err = 0.
  - Parity 0 → core_drive unchanged, par_err = 1 with done.
